// File: rtl/i2s_tdm_tx.sv
// Multi-line I2S / left-justified / right-justified serial audio transmitter.
// A fractional NCO paces sclk; each line shifts its own stereo pair from a per-frame shadow copy.
module i2s_tdm_tx #(
  parameter int I2S_FREQ = 48000,
  parameter int AUDIO_DW = 16,
  parameter int SLOT_DW  = 32,
  parameter int LINES    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   clk_rate,
  input  logic [1:0]                    fmt,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LINES*2*AUDIO_DW-1:0]   s_data,
  output logic                          sclk,
  output logic                          lrclk,
  output logic [LINES-1:0]              sdata,
  output logic                          underrun
);

  localparam int              FRAME_BITS = 2 * SLOT_DW;
  localparam int              PW         = $clog2(FRAME_BITS);
  localparam int              SDW        = LINES * 2 * AUDIO_DW;
  localparam int              PAD        = SLOT_DW - AUDIO_DW;
  localparam logic [32:0]     INC        = 33'(I2S_FREQ * 2 * SLOT_DW * 2);
  localparam logic [PW-1:0]   P_LAST     = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0]   P_SLOT     = PW'(SLOT_DW);

  typedef enum logic [1:0] {
    FMT_I2S     = 2'd0,
    FMT_LJ      = 2'd1,
    FMT_RJ      = 2'd2,
    FMT_I2S_ALT = 2'd3
  } fmt_t;

  logic [31:0]    acc_reg;
  logic           ce_reg;
  logic           sclk_reg;
  logic           lrclk_reg;
  logic [PW-1:0]  p_reg;
  logic [LINES-1:0] sdata_reg;
  logic [LINES-1:0] delay_reg;
  logic           underrun_reg;
  logic           ready_reg;
  fmt_t           fmt_reg;
  logic [SDW-1:0] hold_reg;
  logic           hold_full_reg;
  logic [SDW-1:0] shadow_reg;

  logic [32:0]    acc_sum;
  logic [32:0]    acc_diff;
  logic           nco_wrap;
  logic           fall;
  logic           frame_start;
  logic [PW-1:0]  p_next;
  logic           slot_right;
  logic [PW-1:0]  k;
  logic           take;
  logic           starve;
  logic           hold_full_next;
  logic [SDW-1:0] shadow_next;
  fmt_t           fmt_next;
  logic [LINES-1:0] lj_bit;
  logic [LINES-1:0] bit_next;

  // Widened by one bit so acc + INC can never wrap before the compare.
  assign acc_sum  = {1'b0, acc_reg} + INC;
  assign acc_diff = acc_sum - {1'b0, clk_rate};
  assign nco_wrap = (acc_sum >= {1'b0, clk_rate});

  assign fall        = ce_reg & sclk_reg;
  assign frame_start = fall & (p_reg == P_LAST);
  assign p_next      = (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
  assign slot_right  = (p_next >= P_SLOT);
  assign k           = slot_right ? (p_next - P_SLOT) : p_next;

  assign take           = s_valid & ready_reg;
  assign starve         = frame_start & ~hold_full_reg & ~s_valid;
  assign hold_full_next = frame_start ? 1'b0 : (hold_full_reg | take);

  // The frame being started uses the new sample and format from its very first bit.
  always_comb begin
    shadow_next = shadow_reg;
    fmt_next    = fmt_reg;
    if (frame_start) begin
      fmt_next = fmt_t'(fmt);
      if (hold_full_reg) begin
        shadow_next = hold_reg;
      end else if (s_valid) begin
        shadow_next = s_data;
      end else begin
        shadow_next = '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic [AUDIO_DW-1:0] sample;
      logic [SLOT_DW-1:0]  slot_rj;
      logic [SLOT_DW-1:0]  slot_lj;
      logic [SLOT_DW-1:0]  lj_shift;
      logic [SLOT_DW-1:0]  rj_shift;

      assign sample = slot_right ? shadow_next[gi*2*AUDIO_DW + AUDIO_DW +: AUDIO_DW]
                                 : shadow_next[gi*2*AUDIO_DW +: AUDIO_DW];
      // Place the sample inside a slot-wide word, then the slot bit k is the MSB after shifting by k.
      assign slot_rj  = SLOT_DW'(sample);
      assign slot_lj  = slot_rj << PAD;
      assign lj_shift = slot_lj << k;
      assign rj_shift = slot_rj << k;

      assign lj_bit[gi]   = lj_shift[SLOT_DW-1];
      assign bit_next[gi] = (fmt_next == FMT_LJ) ? lj_bit[gi] :
                            (fmt_next == FMT_RJ) ? rj_shift[SLOT_DW-1] :
                                                   delay_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      ce_reg        <= 1'b0;
      sclk_reg      <= 1'b1;
      lrclk_reg     <= 1'b1;
      p_reg         <= P_LAST;
      sdata_reg     <= '0;
      delay_reg     <= '0;
      underrun_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      fmt_reg       <= FMT_I2S;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      shadow_reg    <= '0;
    end else begin
      acc_reg <= nco_wrap ? acc_diff[31:0] : acc_sum[31:0];
      ce_reg  <= nco_wrap;
      if (ce_reg) begin
        sclk_reg <= ~sclk_reg;
      end
      if (fall) begin
        p_reg      <= p_next;
        lrclk_reg  <= slot_right;
        sdata_reg  <= bit_next;
        delay_reg  <= lj_bit;
        shadow_reg <= shadow_next;
        fmt_reg    <= fmt_next;
      end
      if (take & ~frame_start) begin
        hold_reg <= s_data;
      end
      hold_full_reg <= hold_full_next;
      ready_reg     <= ~hold_full_next;
      underrun_reg  <= starve;
    end
  end

  assign s_ready  = ready_reg;
  assign sclk     = sclk_reg;
  assign lrclk    = lrclk_reg;
  assign sdata    = sdata_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Bench for i2s_tdm_tx: per-cycle comparison against a frame/bit-position model,
// plus literal checks on timing and on three known sample patterns.
module tb_i2s_tdm_tx;

  localparam int     AW   = 24;
  localparam int     SW   = 32;
  localparam int     LN   = 2;
  localparam int     FREQ = 48000;
  localparam longint INC  = longint'(FREQ) * 2 * SW * 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       clk_rate = 32'd24576000;
  logic [1:0]        fmt = 2'd0;
  logic              s_valid = 1'b0;
  logic [LN*2*AW-1:0] s_data = '0;
  logic              s_ready;
  logic              sclk;
  logic              lrclk;
  logic [LN-1:0]     sdata;
  logic              underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tdm_tx #(.I2S_FREQ(FREQ), .AUDIO_DW(AW), .SLOT_DW(SW), .LINES(LN)) dut (
    .clk(clk), .reset(reset), .clk_rate(clk_rate), .fmt(fmt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  // ---------------- behavioural model ----------------
  longint            k_edges;
  int                falls;
  int                m_p;
  int                frame_cnt = 0;
  bit                ce_pend, m_sclk, m_lrclk, m_hold_full, m_ready, m_underrun;
  bit                model_ok = 1'b0;
  logic [LN*2*AW-1:0] m_hold, m_shadow, m_prev;
  logic [1:0]        m_fmt;
  logic [LN-1:0]     m_sdata;

  function automatic bit lj_of(logic [LN*2*AW-1:0] sh, int ln, int p);
    int slot = p / SW;
    int kk   = p % SW;
    if (kk < AW) return sh[ln*2*AW + slot*AW + AW-1-kk];
    return 1'b0;
  endfunction

  function automatic bit rj_of(logic [LN*2*AW-1:0] sh, int ln, int p);
    int slot = p / SW;
    int kk   = p % SW;
    if (kk >= SW-AW) return sh[ln*2*AW + slot*AW + SW-1-kk];
    return 1'b0;
  endfunction

  function automatic bit exp_bit(logic [1:0] f, logic [LN*2*AW-1:0] sh,
                                 logic [LN*2*AW-1:0] prev, int ln, int p);
    if (f == 2'd1) return lj_of(sh, ln, p);
    if (f == 2'd2) return rj_of(sh, ln, p);
    if (p == 0) return lj_of(prev, ln, 2*SW-1);
    return lj_of(sh, ln, p-1);
  endfunction

  initial begin
    bit     do_ce, fall, fstart, ready_now;
    longint r;
    forever begin
      @(posedge clk);
      if (reset) begin
        k_edges = 0; ce_pend = 0; falls = 0; m_p = 2*SW-1;
        m_sclk = 1; m_lrclk = 1; m_sdata = '0; m_hold = '0; m_hold_full = 0;
        m_ready = 0; m_underrun = 0; m_shadow = '0; m_prev = '0; m_fmt = 2'd0;
      end else begin
        r = longint'(clk_rate);
        do_ce = ce_pend;
        k_edges++;
        ce_pend = ((k_edges*INC)/r) != (((k_edges-1)*INC)/r);
        ready_now = m_ready;
        fall = do_ce && m_sclk;
        fstart = 0;
        m_underrun = 0;
        if (do_ce) m_sclk = !m_sclk;
        if (fall) begin
          falls++;
          m_p = (falls-1) % (2*SW);
          m_lrclk = (m_p >= SW);
          fstart = (m_p == 0);
        end
        if (fstart) begin
          m_fmt = fmt;
          m_prev = m_shadow;
          frame_cnt++;
          if (m_hold_full) begin
            m_shadow = m_hold;
            m_hold_full = 0;
          end else if (s_valid) begin
            m_shadow = s_data;
            $display("xfer t=%0t data=%h direct", $time, s_data);
          end else begin
            m_shadow = '0;
            m_underrun = 1;
          end
        end else if (s_valid && ready_now) begin
          m_hold = s_data;
          m_hold_full = 1;
          $display("xfer t=%0t data=%h", $time, s_data);
        end
        if (fall) begin
          for (int ln = 0; ln < LN; ln++) m_sdata[ln] = exp_bit(m_fmt, m_shadow, m_prev, ln, m_p);
        end
        m_ready = !m_hold_full;
      end
      model_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare + slot collector ----------------
  logic [31:0] left_acc [LN];
  logic [31:0] right_acc [LN];
  logic [31:0] left_done [LN];
  logic [31:0] right_done [LN];
  int          left_cnt = 0;
  int          right_cnt = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_lr = 1'b1;

  initial begin
    logic [5:0] got, exp;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        got = {sclk, lrclk, sdata, s_ready, underrun};
        exp = {m_sclk, m_lrclk, m_sdata, m_ready, m_underrun};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got={sclk,lrclk,sdata,rdy,unr}=%b exp=%b", $time, got, exp);
        end
      end
      if (prev_sclk === 1'b1 && sclk === 1'b0) begin
        if (lrclk === 1'b1 && prev_lr === 1'b0) begin
          for (int ln = 0; ln < LN; ln++) left_done[ln] = left_acc[ln];
          left_cnt++;
        end
        if (lrclk === 1'b0 && prev_lr === 1'b1) begin
          for (int ln = 0; ln < LN; ln++) right_done[ln] = right_acc[ln];
          right_cnt++;
        end
        for (int ln = 0; ln < LN; ln++) begin
          if (lrclk) right_acc[ln] = {right_acc[ln][30:0], sdata[ln]};
          else       left_acc[ln]  = {left_acc[ln][30:0], sdata[ln]};
        end
      end
      prev_sclk = sclk;
      prev_lr   = lrclk;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic timeout_fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic wait_frame();
    int start = frame_cnt;
    int n = 0;
    while (frame_cnt == start && n < 3000) begin @(negedge clk); n++; end
    if (frame_cnt == start) timeout_fail("wait_frame");
  endtask

  task automatic wait_left();
    int start = left_cnt;
    int n = 0;
    while (left_cnt == start && n < 3000) begin @(posedge clk); n++; end
    if (left_cnt == start) timeout_fail("wait_left");
  endtask

  task automatic wait_right();
    int start = right_cnt;
    int n = 0;
    while (right_cnt == start && n < 3000) begin @(posedge clk); n++; end
    if (right_cnt == start) timeout_fail("wait_right");
  endtask

  task automatic sclk_half();
    int   n = 0;
    logic s0 = sclk;
    do begin @(negedge clk); n++; end while (sclk === s0 && n < 50);
    chk("sclk_half_period", n, 4);
  endtask

  task automatic lr_rise(output int n);
    logic pl = lrclk;
    bit   ok = 0;
    n = 0;
    while (!ok && n < 2000) begin
      @(negedge clk); n++;
      ok = (pl === 1'b0 && lrclk === 1'b1);
      pl = lrclk;
    end
    if (!ok) timeout_fail("lrclk_rise");
  endtask

  task automatic directed(string nm, logic [1:0] f, logic [LN*2*AW-1:0] d,
                          logic [31:0] e_l0, logic [31:0] e_r0, logic [31:0] e_l1);
    wait_frame();
    fmt = f; s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0; s_data = {$urandom, $urandom, $urandom};
    chk({nm, "_ready_low"}, s_ready, 0);
    wait_frame();
    wait_left();
    chk({nm, "_left0"}, left_done[0], e_l0);
    chk({nm, "_left1"}, left_done[1], e_l1);
    wait_right();
    chk({nm, "_right0"}, right_done[0], e_r0);
    @(negedge clk);
  endtask

  task automatic rand_run(int ncyc);
    int thresh = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i % 1000 == 0) begin
        case ($urandom_range(0, 2))
          0:       thresh = 0;
          1:       thresh = 3;
          default: thresh = 400;
        endcase
      end
      s_valid = ($urandom_range(0, 999) < thresh);
      s_data  = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 499) == 0) fmt = 2'($urandom_range(0, 3));
    end
    s_valid = 1'b0;
  endtask

  // L0=A5C3F0, R0=800001, L1=123456, R1=654321
  localparam logic [LN*2*AW-1:0] PAT = {24'h654321, 24'h123456, 24'h800001, 24'hA5C3F0};

  initial begin
    int n, cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sclk, lrclk, sdata, s_ready, underrun}, 6'b110000);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", s_ready, 1);
    n = 1;
    while (sclk !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("first_fall_clk", n, 5);
    chk("first_fall_lrclk", lrclk, 0);
    sclk_half();
    sclk_half();
    lr_rise(n);
    lr_rise(n);
    chk("lrclk_period", n, 512);

    directed("lj",  2'd1, PAT, 32'hA5C3F000, 32'h80000100, 32'h12345600);
    directed("rj",  2'd2, PAT, 32'h00A5C3F0, 32'h00800001, 32'h00123456);
    directed("i2s", 2'd0, PAT, 32'h52E1F800, 32'h40000080, 32'h091A2B00);

    // No sample offered: exactly one underrun pulse in one frame period.
    s_valid = 1'b0;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (underrun === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("underrun_width", cnt, 1);
    chk("underrun_ready", s_ready, 1);

    // Sample offered on the very clk of frame start goes straight out, no underrun.
    wait_frame();
    repeat (511) @(negedge clk);
    fmt = 2'd1; s_valid = 1'b1; s_data = PAT;
    @(negedge clk);
    s_valid = 1'b0;
    chk("direct_no_underrun", underrun, 0);
    chk("direct_ready", s_ready, 1);
    wait_left();
    chk("direct_left0", left_done[0], 32'hA5C3F000);
    @(negedge clk);

    rand_run(5000);

    n = 0;
    while (m_p != 40 && n < 5000) begin @(negedge clk); n++; end
    if (m_p != 40) timeout_fail("reach_p40");
    reset = 1'b1;
    @(negedge clk);
    chk("midframe_reset", {sclk, lrclk, sdata, s_ready, underrun}, 6'b110000);
    clk_rate = 32'd30000000;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    rand_run(8000);
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
